oser8_link_ctrl: RTL and testbench

- Single-lane transmit controller in front of the 8:1 output serializer (OSER8, one lane, OBUF-driven).
- Runs in the serializer's pclk domain.
- Sequences the serializer reset and link training.
- Frames a byte stream from one upstream requester: SYNC word, payload bytes, then IDLE fill.
- Presents one registered 8-bit word per pclk to the serializer din. din[0] is transmitted first.

---
 rtl/oser8_link_ctrl.sv | 154 +++++++++++++++
 tb/tb_oser8_link_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/oser8_link_ctrl.sv
// Single-lane transmit controller for an 8:1 output serializer: sequences the
// serializer reset and word-alignment training, then frames one upstream byte stream.
module oser8_link_ctrl #(
    parameter int          RST_CYCLES    = 4,
    parameter int          TRAIN_WORDS   = 64,
    parameter logic [7:0]  TRAIN_PATTERN = 8'hF0,
    parameter logic [7:0]  IDLE_PATTERN  = 8'hAA,
    parameter logic [7:0]  SYNC_WORD     = 8'hBC,
    parameter logic [7:0]  FILL_WORD     = 8'h1C
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        train_req,
    output logic [7:0]  ser_din,
    output logic        ser_reset,
    output logic        link_up,
    output logic        underrun,
    output logic [15:0] frame_cnt
);

    localparam int CNT_MAX = (RST_CYCLES > TRAIN_WORDS) ? RST_CYCLES : TRAIN_WORDS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TRAIN_LAST = CW'(TRAIN_WORDS);

    typedef enum logic [2:0] {
        RST_SER,
        TRAIN,
        IDLE,
        SOF,
        DATA
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          train_pend, train_pend_d;
    logic [7:0]    ser_din_d;
    logic          ser_reset_d;
    logic          link_up_d;
    logic          underrun_d;
    logic [15:0]   frame_cnt_d;

    assign in_ready = (state == SOF) || (state == DATA);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; an unassigned path in always_comb infers a latch.
        state_d      = state;
        cnt_d        = cnt;
        train_pend_d = train_pend;
        ser_din_d    = ser_din;
        ser_reset_d  = ser_reset;
        link_up_d    = link_up;
        underrun_d   = 1'b0;
        frame_cnt_d  = frame_cnt;

        case (state)
            RST_SER: begin
                if (cnt == RST_LAST) begin
                    // First training word goes out on the same edge ser_reset falls.
                    state_d     = TRAIN;
                    cnt_d       = CW'(1);
                    ser_din_d   = TRAIN_PATTERN;
                    ser_reset_d = 1'b0;
                end else begin
                    cnt_d     = cnt + CW'(1);
                    ser_din_d = 8'h00;
                end
            end

            TRAIN: begin
                // cnt holds the number of training words already on ser_din.
                train_pend_d = 1'b0;
                if (cnt == TRAIN_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    ser_din_d = IDLE_PATTERN;
                    link_up_d = 1'b1;
                end else begin
                    cnt_d     = cnt + CW'(1);
                    ser_din_d = TRAIN_PATTERN;
                    link_up_d = 1'b0;
                end
            end

            IDLE: begin
                if (train_req) train_pend_d = 1'b1;
                if (train_pend) begin
                    state_d      = TRAIN;
                    cnt_d        = '0;
                    train_pend_d = 1'b0;
                    ser_din_d    = IDLE_PATTERN;
                end else if (in_valid) begin
                    state_d   = SOF;
                    ser_din_d = SYNC_WORD;
                end else begin
                    ser_din_d = IDLE_PATTERN;
                end
            end

            SOF, DATA: begin
                if (train_req) train_pend_d = 1'b1;
                if (in_valid) begin
                    ser_din_d = in_data;
                    if (in_last) begin
                        state_d     = IDLE;
                        frame_cnt_d = frame_cnt + 16'd1;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    // Mid-frame underrun keeps the frame open with filler.
                    ser_din_d  = FILL_WORD;
                    underrun_d = 1'b1;
                end
            end

            default: begin
                state_d = RST_SER;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RST_SER;
            cnt        <= '0;
            train_pend <= 1'b0;
            ser_din    <= 8'h00;
            ser_reset  <= 1'b1;
            link_up    <= 1'b0;
            underrun   <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values computed in always_comb, independent of statement order.
            state      <= state_d;
            cnt        <= cnt_d;
            train_pend <= train_pend_d;
            ser_din    <= ser_din_d;
            ser_reset  <= ser_reset_d;
            link_up    <= link_up_d;
            underrun   <= underrun_d;
            frame_cnt  <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_oser8_link_ctrl.sv
// Directed self-checking bench for oser8_link_ctrl: bring-up, framing, underrun,
// retraining at a frame boundary, asynchronous reset and frame counter wrap.
module tb_oser8_link_ctrl;

    localparam int RST_CYCLES  = 4;
    localparam int TRAIN_WORDS = 64;

    logic        pclk;
    logic        reset_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        train_req;
    logic [7:0]  ser_din;
    logic        ser_reset;
    logic        link_up;
    logic        underrun;
    logic [15:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    oser8_link_ctrl dut (
        .pclk      (pclk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .train_req (train_req),
        .ser_din   (ser_din),
        .ser_reset (ser_reset),
        .link_up   (link_up),
        .underrun  (underrun),
        .frame_cnt (frame_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Word on ser_din plus the flags that accompany it.
    task automatic expect_word(input string tag, input logic [7:0] din, input logic lu,
                               input logic ur, input logic rdy);
        check({tag, ".din"}, {8'h00, ser_din}, {8'h00, din});
        check({tag, ".link_up"}, {15'd0, link_up}, {15'd0, lu});
        check({tag, ".underrun"}, {15'd0, underrun}, {15'd0, ur});
        check({tag, ".in_ready"}, {15'd0, in_ready}, {15'd0, rdy});
    endtask

    // Release reset just after an edge and walk the full reset/training sequence.
    task automatic bring_up(input string tag);
        reset_n = 1'b1;
        check({tag, ".ser_reset_c1"}, {15'd0, ser_reset}, 16'd1);
        expect_word({tag, ".rst_c1"}, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= RST_CYCLES; i++) begin
            tick();
            check($sformatf("%s.ser_reset_c%0d", tag, i), {15'd0, ser_reset}, 16'd1);
            expect_word($sformatf("%s.rst_c%0d", tag, i), 8'h00, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 1; i <= TRAIN_WORDS; i++) begin
            tick();
            check($sformatf("%s.ser_reset_t%0d", tag, i), {15'd0, ser_reset}, 16'd0);
            expect_word($sformatf("%s.train_%0d", tag, i), 8'hF0, 1'b0, 1'b0, 1'b0);
        end
        tick();
        expect_word({tag, ".first_idle"}, 8'hAA, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        train_req = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst.ser_reset", {15'd0, ser_reset}, 16'd1);
        check("rst.frame_cnt", frame_cnt, 16'h0000);
        expect_word("rst", 8'h00, 1'b0, 1'b0, 1'b0);

        // 1: bring-up
        bring_up("up1");

        // 2: 3-byte frame 11,22,33
        in_valid = 1'b1; in_data = 8'h11; in_last = 1'b0;
        check("f1.idle_ready", {15'd0, in_ready}, 16'd0);
        tick(); expect_word("f1.sync", 8'hBC, 1'b1, 1'b0, 1'b1);
        tick(); expect_word("f1.b0", 8'h11, 1'b1, 1'b0, 1'b1);
        in_data = 8'h22;
        tick(); expect_word("f1.b1", 8'h22, 1'b1, 1'b0, 1'b1);
        in_data = 8'h33; in_last = 1'b1;
        tick(); expect_word("f1.b2", 8'h33, 1'b1, 1'b0, 1'b0);
        check("f1.frame_cnt", frame_cnt, 16'd1);
        in_valid = 1'b0; in_last = 1'b0;
        tick(); expect_word("f1.idle", 8'hAA, 1'b1, 1'b0, 1'b0);

        // 3: back-to-back frames 01,02L then 03L
        in_valid = 1'b1; in_data = 8'h01; in_last = 1'b0;
        tick(); expect_word("b2b.sync0", 8'hBC, 1'b1, 1'b0, 1'b1);
        tick(); expect_word("b2b.b01", 8'h01, 1'b1, 1'b0, 1'b1);
        in_data = 8'h02; in_last = 1'b1;
        tick(); expect_word("b2b.b02", 8'h02, 1'b1, 1'b0, 1'b0);
        in_data = 8'h03; in_last = 1'b1;
        tick(); expect_word("b2b.sync1", 8'hBC, 1'b1, 1'b0, 1'b1);
        tick(); expect_word("b2b.b03", 8'h03, 1'b1, 1'b0, 1'b0);
        check("b2b.frame_cnt", frame_cnt, 16'd3);
        in_valid = 1'b0; in_last = 1'b0;
        tick(); expect_word("b2b.idle", 8'hAA, 1'b1, 1'b0, 1'b0);

        // 4: two-cycle underrun after byte 11
        in_valid = 1'b1; in_data = 8'h11; in_last = 1'b0;
        tick(); expect_word("ur.sync", 8'hBC, 1'b1, 1'b0, 1'b1);
        tick(); expect_word("ur.b11", 8'h11, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b0;
        tick(); expect_word("ur.fill0", 8'h1C, 1'b1, 1'b1, 1'b1);
        tick(); expect_word("ur.fill1", 8'h1C, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b1; in_data = 8'h22; in_last = 1'b1;
        tick(); expect_word("ur.b22", 8'h22, 1'b1, 1'b0, 1'b0);
        check("ur.frame_cnt", frame_cnt, 16'd4);
        in_valid = 1'b0; in_last = 1'b0;
        tick(); expect_word("ur.idle", 8'hAA, 1'b1, 1'b0, 1'b0);

        // 5: retrain requested during byte 2 of a 4-byte frame
        in_valid = 1'b1; in_data = 8'hA1; in_last = 1'b0;
        tick(); expect_word("tr.sync", 8'hBC, 1'b1, 1'b0, 1'b1);
        tick(); expect_word("tr.a1", 8'hA1, 1'b1, 1'b0, 1'b1);
        in_data = 8'hA2; train_req = 1'b1;
        tick(); expect_word("tr.a2", 8'hA2, 1'b1, 1'b0, 1'b1);
        in_data = 8'hA3; train_req = 1'b0;
        tick(); expect_word("tr.a3", 8'hA3, 1'b1, 1'b0, 1'b1);
        in_data = 8'hA4; in_last = 1'b1;
        tick(); expect_word("tr.a4", 8'hA4, 1'b1, 1'b0, 1'b0);
        check("tr.frame_cnt", frame_cnt, 16'd5);
        in_data = 8'hB1; in_last = 1'b1;
        tick(); expect_word("tr.idle", 8'hAA, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= TRAIN_WORDS; i++) begin
            tick();
            expect_word($sformatf("tr.train_%0d", i), 8'hF0, 1'b0, 1'b0, 1'b0);
        end
        tick(); expect_word("tr.first_idle", 8'hAA, 1'b1, 1'b0, 1'b0);
        tick(); expect_word("tr.sync2", 8'hBC, 1'b1, 1'b0, 1'b1);
        tick(); expect_word("tr.b1", 8'hB1, 1'b1, 1'b0, 1'b0);
        check("tr.frame_cnt2", frame_cnt, 16'd6);
        in_valid = 1'b0; in_last = 1'b0;
        tick(); expect_word("tr.idle2", 8'hAA, 1'b1, 1'b0, 1'b0);

        // 6: asynchronous reset mid-frame, then full re-bring-up
        in_valid = 1'b1; in_data = 8'hC1; in_last = 1'b0;
        tick(); expect_word("ar.sync", 8'hBC, 1'b1, 1'b0, 1'b1);
        tick(); expect_word("ar.c1", 8'hC1, 1'b1, 1'b0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("ar.ser_reset", {15'd0, ser_reset}, 16'd1);
        check("ar.frame_cnt", frame_cnt, 16'h0000);
        expect_word("ar", 8'h00, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        bring_up("up2");

        // Frame counter wrap from FFFF
        @(negedge pclk);
        force dut.frame_cnt = 16'hFFFF;
        #1 release dut.frame_cnt;
        tick();
        check("wrap.preload", frame_cnt, 16'hFFFF);
        in_valid = 1'b1; in_data = 8'hD1; in_last = 1'b1;
        tick(); expect_word("wrap.sync", 8'hBC, 1'b1, 1'b0, 1'b1);
        tick(); expect_word("wrap.d1", 8'hD1, 1'b1, 1'b0, 1'b0);
        check("wrap.frame_cnt", frame_cnt, 16'h0000);
        in_valid = 1'b0; in_last = 1'b0;
        tick(); expect_word("wrap.idle", 8'hAA, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
